// File: rtl/hack_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hack_ram_ctrl
// Brief    : Hack CPU data RAM with a valid/ready request port, registered
//            1-cycle read data and a hardware zero-fill sweep that runs after
//            every reset and whenever clear_req is pulsed while idle.
// Revision : 1.0 - initial release
// ============================================================================
module hack_ram_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clear_req,
  output logic              busy
);

  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_PTR_W-1:0]  r_ptr;
  logic                r_req_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_fire;
  logic                w_in_range;
  logic [c_PTR_W-1:0]  w_idx;

  // A transfer happens only when the block advertised ready (IDLE only).
  assign w_fire     = req_valid & r_req_ready;
  // Addresses at or beyond DEPTH map to nothing: writes dropped, reads give 0.
  assign w_in_range = ({{(32 - ADDR_W){1'b0}}, req_addr} < 32'(DEPTH));
  assign w_idx      = req_addr[c_PTR_W-1:0];

  // Array write port: the sweep owns the port in CLEAR, requests own it in IDLE.
  always_ff @(posedge clock) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_fire && req_we && w_in_range) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  // Control FSM, sweep pointer and registered response/status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_CLEAR;
      r_ptr       <= '0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_fire & ~req_we;
      if (w_fire && !req_we) begin
        r_rsp_rdata <= w_in_range ? r_mem[w_idx] : '0;
      end

      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == c_LAST) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          // A request accepted on this same edge completes before the sweep starts.
          if (clear_req) begin
            r_state     <= ST_CLEAR;
            r_ptr       <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_ptr       <= '0;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_hack_ram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hack_ram_ctrl
// Brief    : Self-checking bench for hack_ram_ctrl (DEPTH=16). Read data is
//            checked through an expected-value queue filled when reads are
//            issued and drained when rsp_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_ram_ctrl;

  localparam int c_DATA_W = 16;
  localparam int c_ADDR_W = 14;
  localparam int c_DEPTH  = 16;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [c_ADDR_W-1:0] req_addr;
  logic [c_DATA_W-1:0] req_wdata;
  logic                rsp_valid;
  logic [c_DATA_W-1:0] rsp_rdata;
  logic                clear_req;
  logic                busy;

  int checks = 0;
  int errors = 0;
  logic [c_DATA_W-1:0] exp_q [$];

  typedef struct {
    logic                we;
    logic [c_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0] wdata;
    logic [c_DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  hack_ram_ctrl #(
    .DATA_W(c_DATA_W),
    .ADDR_W(c_ADDR_W),
    .DEPTH (c_DEPTH)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .clear_req(clear_req),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest issued read.
  always @(posedge clock) begin
    #1;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata %0h with no read outstanding", rsp_rdata);
      end else begin
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic we, input logic [c_ADDR_W-1:0] addr,
                       input logic [c_DATA_W-1:0] wd, input logic [c_DATA_W-1:0] exp);
    @(negedge clock);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    if (!we) exp_q.push_back(exp);
  endtask

  task automatic idle_bus(input int n);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Counts negedge samples with busy=1, starting at the current time. While
  // busy, optionally presents a write of 0x7777 to addr 3 that must be ignored.
  task automatic count_busy(input logic junk, output int n, output int ready_bad);
    n = 0;
    ready_bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy !== 1'b1) begin
        req_valid = 1'b0;
        break;
      end
      n++;
      if (req_ready !== 1'b0) ready_bad++;
      req_valid = junk;
      req_we    = 1'b1;
      req_addr  = 14'd3;
      req_wdata = 16'h7777;
      @(negedge clock);
    end
    req_valid = 1'b0;
  endtask

  task automatic read_all(input logic [c_DATA_W-1:0] exp);
    for (int a = 0; a < c_DEPTH; a++) issue(1'b0, c_ADDR_W'(a), '0, exp);
    idle_bus(3);
  endtask

  int n_busy;
  int n_bad;

  initial begin
    vecs[0]  = '{1'b1, 14'd5,  16'h1234, 16'h0000};
    vecs[1]  = '{1'b0, 14'd5,  16'h0000, 16'h1234};
    vecs[2]  = '{1'b1, 14'd1,  16'h000A, 16'h0000};
    vecs[3]  = '{1'b1, 14'd2,  16'h000B, 16'h0000};
    vecs[4]  = '{1'b1, 14'd3,  16'h000C, 16'h0000};
    vecs[5]  = '{1'b0, 14'd1,  16'h0000, 16'h000A};
    vecs[6]  = '{1'b0, 14'd2,  16'h0000, 16'h000B};
    vecs[7]  = '{1'b0, 14'd3,  16'h0000, 16'h000C};
    vecs[8]  = '{1'b1, 14'd20, 16'hBEEF, 16'h0000};
    vecs[9]  = '{1'b0, 14'd20, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 14'd4,  16'h0000, 16'h0000};
    vecs[11] = '{1'b1, 14'd15, 16'h5555, 16'h0000};
    vecs[12] = '{1'b0, 14'd15, 16'h0000, 16'h5555};
    vecs[13] = '{1'b0, 14'd5,  16'h0000, 16'h1234};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clear_req = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy",      32'(busy),      32'd1);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);

    // Power-on sweep length, ready afterwards, and all words zero.
    reset_n = 1'b1;
    count_busy(1'b0, n_busy, n_bad);
    check("init_sweep_cycles", 32'(n_busy), 32'd16);
    check("init_ready_low",    32'(n_bad),  32'd0);
    check("init_ready_after",  32'(req_ready), 32'd1);
    read_all(16'h0000);

    // Table: write/readback, ordered back-to-back reads, out-of-range access.
    foreach (vecs[i]) issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    idle_bus(3);

    // Fill with 0xFFFF, then clear_req alongside a read that must still complete.
    for (int a = 0; a < c_DEPTH; a++) issue(1'b1, c_ADDR_W'(a), 16'hFFFF, '0);
    issue(1'b0, 14'd7, '0, 16'hFFFF);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    req_valid = 1'b0;
    count_busy(1'b1, n_busy, n_bad);
    check("clear_sweep_cycles", 32'(n_busy), 32'd16);
    check("clear_ready_low",    32'(n_bad),  32'd0);
    check("clear_ready_after",  32'(req_ready), 32'd1);
    check("clear_queue_empty",  32'(exp_q.size()), 32'd0);
    read_all(16'h0000);

    // Reset at cycle 7 of a sweep: full-length sweep must follow release.
    issue(1'b1, 14'd9, 16'h4242, '0);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    req_valid = 1'b0;
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midsweep_rst_busy",  32'(busy),      32'd1);
    check("midsweep_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    count_busy(1'b0, n_busy, n_bad);
    check("restart_sweep_cycles", 32'(n_busy), 32'd16);
    read_all(16'h0000);

    // Reset right after a read is accepted: the pending response is dropped.
    issue(1'b1, 14'd6, 16'hCAFE, '0);
    @(negedge clock);
    req_we   = 1'b0;
    req_addr = 14'd6;
    @(posedge clock);
    #0.5;
    reset_n = 1'b0;
    #0.1;
    check("rdrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rdrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rdrst_busy",      32'(busy),      32'd1);
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    count_busy(1'b0, n_busy, n_bad);
    check("rdrst_sweep_cycles", 32'(n_busy), 32'd16);
    issue(1'b0, 14'd6, '0, 16'h0000);
    idle_bus(3);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
